// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter for the serial bit link.
// A word is taken over a valid/ready handshake into a one-entry holding
// buffer, then shifted out one bit per shift_enable cycle. A word waiting in
// the buffer when the last bit of the current word is consumed follows with
// no idle bit in between.
//
// Ports:
//   clock         system clock, rising edge
//   reset_n       synchronous active-low reset
//   load_data     word to transmit (WIDTH bits)
//   load_valid    load_data is valid
//   load_ready    holding buffer can accept a word
//   shift_enable  bit pacing strobe shared with the receiver
//   serial_out    current serial bit
//   serial_valid  serial_out carries a frame bit
//   busy          word held or being shifted
//   done          one-cycle pulse after the last bit of a word is consumed
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_enable,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic             hold_full;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;
  logic             last_bit;

  // Ready depends only on registered state, gated low while in reset
  assign load_ready = reset_n && !hold_full;
  assign accept     = load_valid && load_ready;
  assign last_bit   = (bit_cnt == LAST_CNT);

  assign serial_valid = (state == SHIFT);
  assign serial_out   = (state == SHIFT) &&
                        (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);
  assign busy         = (state == SHIFT) || hold_full;

  // Holding buffer, shift engine and done pulse
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      hold      <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      // Accept never coincides with a pull: ready is low while hold is full
      if (accept) begin
        hold      <= load_data;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (hold_full) begin
            shift_reg <= hold;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (shift_enable) begin
            // Zero fill leaves shift_reg clear once a word has fully drained
            if (MSB_FIRST) begin
              shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            end else begin
              shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
            end
            bit_cnt <= bit_cnt + CNT_W'(1);

            if (last_bit) begin
              done <= 1'b1;
              if (hold_full) begin
                // Chain the next word with no idle bit
                shift_reg <= hold;
                hold_full <= 1'b0;
                bit_cnt   <= '0;
              end else begin
                state <= IDLE;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: an MSB-first and an LSB-first instance share
// all inputs and are compared every cycle against a word/bit-position model,
// plus an end-to-end expected bit stream and a loopback receiver.
module tb_piso_serializer;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_valid = 1'b0;
  logic         shift_enable = 1'b0;

  logic ready_m, so_m, sv_m, busy_m, done_m;
  logic ready_l, so_l, sv_l, busy_l, done_l;

  always #5 clock = ~clock;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .load_ready   (ready_m),
    .shift_enable (shift_enable),
    .serial_out   (so_m),
    .serial_valid (sv_m),
    .busy         (busy_m),
    .done         (done_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .load_ready   (ready_l),
    .shift_enable (shift_enable),
    .serial_out   (so_l),
    .serial_valid (sv_l),
    .busy         (busy_l),
    .done         (done_l)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending word, word on the wire and its bit position
  logic         m_hold_full = 1'b0;
  logic [W-1:0] m_hold = '0;
  logic         m_active = 1'b0;
  logic [W-1:0] m_word = '0;
  int           m_pos = 0;
  logic         m_done = 1'b0;

  // Expected bit streams in transmit order, built at accept time
  logic exp_m[$];
  logic exp_l[$];

  logic [W-1:0] cap_m = '0;
  logic [W-1:0] cap_l = '0;
  logic [W-1:0] rx = '0;
  logic         acc_flag = 1'b0;
  logic         chk_rx = 1'b0;
  int           rx_checks = 0;
  int           valid_cnt = 0;
  int           done_cnt = 0;
  int           run = 0;
  int           max_run = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic bit_at(input logic [W-1:0] w, input int pos, input bit msb);
    return msb ? w[W-1-pos] : w[pos];
  endfunction

  // One clock cycle: pre-edge bookkeeping, model update, post-edge checks
  task automatic tick();
    logic acc;
    logic e;
    if (reset_n && m_active && shift_enable) begin
      if (exp_m.size() == 0) check("stream_m_empty", 32'd1, 32'd0);
      else begin e = exp_m.pop_front(); check("stream_m", 32'(so_m), 32'(e)); end
      if (exp_l.size() == 0) check("stream_l_empty", 32'd1, 32'd0);
      else begin e = exp_l.pop_front(); check("stream_l", 32'(so_l), 32'(e)); end
      cap_m = {cap_m[W-2:0], so_m};
      cap_l = {cap_l[W-2:0], so_l};
    end
    if (shift_enable) rx = {rx[W-2:0], so_m};
    acc = reset_n && load_valid && !m_hold_full;
    acc_flag = acc;
    if (acc) begin
      for (int i = 0; i < int'(W); i++) begin
        exp_m.push_back(load_data[W-1-i]);
        exp_l.push_back(load_data[i]);
      end
    end

    @(posedge clock);
    if (!reset_n) begin
      m_hold_full = 1'b0;
      m_active    = 1'b0;
      m_pos       = 0;
      m_done      = 1'b0;
      exp_m.delete();
      exp_l.delete();
    end else begin
      m_done = 1'b0;
      if (!m_active) begin
        if (m_hold_full) begin
          m_active = 1'b1; m_word = m_hold; m_pos = 0; m_hold_full = 1'b0;
        end
      end else if (shift_enable) begin
        m_pos++;
        if (m_pos == int'(W)) begin
          m_done = 1'b1;
          if (m_hold_full) begin
            m_word = m_hold; m_pos = 0; m_hold_full = 1'b0;
          end else begin
            m_active = 1'b0;
            m_pos    = 0;
          end
        end
      end
      if (acc) begin
        m_hold = load_data; m_hold_full = 1'b1;
      end
    end

    @(negedge clock);
    check("valid_m", 32'(sv_m), 32'(m_active));
    check("valid_l", 32'(sv_l), 32'(m_active));
    check("sout_m", 32'(so_m), 32'(m_active && bit_at(m_word, m_pos, 1'b1)));
    check("sout_l", 32'(so_l), 32'(m_active && bit_at(m_word, m_pos, 1'b0)));
    check("ready_m", 32'(ready_m), 32'(reset_n && !m_hold_full));
    check("ready_l", 32'(ready_l), 32'(reset_n && !m_hold_full));
    check("busy_m", 32'(busy_m), 32'(m_active || m_hold_full));
    check("busy_l", 32'(busy_l), 32'(m_active || m_hold_full));
    check("done_m", 32'(done_m), 32'(m_done));
    check("done_l", 32'(done_l), 32'(m_done));
    if (sv_m === 1'b1) valid_cnt++;
    if (done_m === 1'b1) done_cnt++;
    run = (sv_m === 1'b1) ? run + 1 : 0;
    if (run > max_run) max_run = run;
    if (chk_rx && done_m === 1'b1) begin
      check("loopback_rx", 32'(rx), 32'h5A);
      rx_checks++;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a word until the model says it was accepted (bounded)
  task automatic send(input logic [W-1:0] w);
    bit ok;
    ok = 1'b0;
    load_data  = w;
    load_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      ok = acc_flag;
    end
    load_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_stats();
    valid_cnt = 0; done_cnt = 0; run = 0; max_run = 0; cap_m = '0; cap_l = '0;
  endtask

  initial begin
    // Reset
    reset_n = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hEE;
    shift_enable = 1'b1;
    ticks(3);
    check("rst_ready", 32'(ready_m), 32'd0);
    check("rst_busy", 32'(busy_m), 32'd0);
    check("rst_valid", 32'(sv_m), 32'd0);
    load_valid = 1'b0;
    reset_n = 1'b1;
    ticks(2);
    check("post_rst_ready", 32'(ready_m), 32'd1);

    // 1: single word, continuous enable
    clear_stats();
    shift_enable = 1'b1;
    send(8'hA5);
    ticks(12);
    check("t1_valid_cnt", 32'(valid_cnt), 32'd8);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_bits", 32'(cap_m), 32'hA5);
    check("t1_busy_end", 32'(busy_m), 32'd0);

    // 2: back-to-back words, no gap
    clear_stats();
    send(8'hA5);
    ticks(2);
    send(8'h3C);
    ticks(20);
    check("t2_valid_cnt", 32'(valid_cnt), 32'd16);
    check("t2_max_run", 32'(max_run), 32'd16);
    check("t2_done_cnt", 32'(done_cnt), 32'd2);
    check("t2_bits", 32'(cap_m), 32'h3C);

    // 3: enable pattern 1,0,0
    clear_stats();
    shift_enable = 1'b0;
    send(8'hC3);
    for (int i = 0; i < 40; i++) begin
      shift_enable = (i % 3 == 0);
      tick();
    end
    check("t3_done_cnt", 32'(done_cnt), 32'd1);
    check("t3_bits", 32'(cap_m), 32'hC3);

    // 4: reset mid-frame, then a clean word
    clear_stats();
    shift_enable = 1'b1;
    send(8'hFF);
    ticks(4);
    reset_n = 1'b0;
    load_valid = 1'b1;
    tick();
    check("t4_valid", 32'(sv_m), 32'd0);
    check("t4_sout", 32'(so_m), 32'd0);
    check("t4_busy", 32'(busy_m), 32'd0);
    check("t4_ready_rst", 32'(ready_m), 32'd0);
    load_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    check("t4_ready_after", 32'(ready_m), 32'd1);
    check("t4_no_done", 32'(done_cnt), 32'd0);
    clear_stats();
    send(8'h81);
    ticks(12);
    check("t4_bits", 32'(cap_m), 32'h81);
    check("t4_done_cnt", 32'(done_cnt), 32'd1);

    // 5: LSB-first instance sends 01 as 1 then seven 0s
    clear_stats();
    send(8'h01);
    ticks(12);
    check("t5_bits_l", 32'(cap_l), 32'h80);
    check("t5_bits_m", 32'(cap_m), 32'h01);

    // 6: loopback into a shift-in receiver on the shared strobe
    clear_stats();
    rx_checks = 0;
    chk_rx = 1'b1;
    send(8'h5A);
    ticks(12);
    chk_rx = 1'b0;
    check("t6_rx_checked", 32'(rx_checks), 32'd1);

    // Random traffic with occasional reset
    for (int i = 0; i < 500; i++) begin
      reset_n      = ($urandom_range(0, 99) != 0);
      load_valid   = ($urandom_range(0, 2) == 0);
      load_data    = W'($urandom);
      shift_enable = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset_n = 1'b1;
    load_valid = 1'b0;
    shift_enable = 1'b1;
    ticks(30);
    check("drain_m", 32'(exp_m.size()), 32'd0);
    check("drain_l", 32'(exp_l.size()), 32'd0);
    check("drain_busy", 32'(busy_m), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter; the transmit end of the team's serial bit link, whose receiver is the 8-bit serial-in/parallel-out shift register.
- Accepts a WIDTH-bit word over a valid/ready load handshake.
- Holds the word in a one-entry holding buffer, then shifts it out one bit per shift_enable cycle.
- Supports back-to-back words with no idle bit between frames.

Parameters:
- WIDTH, 8, word width in bits (≥2); bit counter is clog2(WIDTH) bits.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- load_data  input  WIDTH  word to transmit.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  holding buffer can accept a word.
- shift_enable  input  1  bit pacing strobe, shared with the receiver; one bit is consumed per high cycle.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries a frame bit.
- busy  output  1  word held or being shifted.
- done  output  1  one-cycle pulse after the last bit of a word is consumed.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports are named clock and reset_n.
- Reset: on a rising edge with reset_n=0, state=IDLE, hold_full=0, shift_reg=0, bit_cnt=0, done=0.
  - load_ready is gated by reset_n, so it is 0 while reset_n=0.
  - serial_out=0, serial_valid=0, busy=0.
- Reset mid-frame aborts immediately: shift_reg and hold are discarded and no done pulse is generated.
- Accept: a word is accepted on an edge with load_valid && load_ready; it is written to hold and hold_full is set.
  - load_ready = reset_n && !hold_full; it is registered-state-derived, with no combinational path from load_valid or shift_enable.
- States: IDLE, SHIFT.
- IDLE:
  - serial_out=0, serial_valid=0.
  - If hold_full: on the next edge, shift_reg<=hold, hold_full<=0, bit_cnt<=0, state<=SHIFT.
  - Latency: a word accepted at edge N appears as serial_valid=1 from edge N+1.
- SHIFT:
  - serial_valid=1; serial_out = shift_reg[WIDTH-1] if MSB_FIRST, else shift_reg[0].
  - A bit is consumed on an edge with shift_enable=1. The receiver samples on the same edge.
  - On consumption, shift_reg shifts toward the output end (zero fill) and bit_cnt increments.
  - shift_enable=0 holds serial_out, shift_reg and bit_cnt unchanged for any number of cycles.
- Last bit: consumption with bit_cnt==WIDTH-1 ends the word, and done=1 for exactly the following cycle.
  - If hold_full: shift_reg<=hold, hold_full<=0, bit_cnt<=0, stay in SHIFT. The next word's first bit is presented on the next cycle with no gap.
  - Else: state<=IDLE.
- Simultaneous events:
  - Accept cannot coincide with a pull from hold, because load_ready=0 whenever hold_full=1.
  - A load accepted in the same cycle the last bit is consumed (hold was empty) goes to hold; the engine passes through IDLE for one cycle, giving a one-cycle gap.
- busy = (state==SHIFT) || hold_full.
- Inputs are ignored while reset_n=0.
- Exactly WIDTH consumed bits per word; no bit is repeated or dropped regardless of shift_enable gaps.

Test Plan:
1. Reset, then load 8'hA5 (MSB_FIRST=1), shift_enable=1 continuously -> serial_valid high for exactly 8 cycles starting the cycle after accept; bits 1,0,1,0,0,1,0,1; done pulses once; busy=0 after done.
2. Load 8'hA5, then 8'h3C while the first word is shifting (accepted while load_ready=1) -> 16 consecutive valid bits 10100101 00111100 with no gap; load_ready=0 from the second accept until the 3C pull; done pulses twice, 8 cycles apart.
3. Load 8'hC3 with shift_enable toggling 1,0,0,1,... -> serial_out stable while shift_enable=0; bit sequence 11000011 is unchanged; done follows the 8th enabled cycle.
4. Reset mid-frame: load 8'hFF, consume 3 bits, assert reset_n=0 for one edge -> next cycle serial_valid=0, serial_out=0, busy=0, load_ready=0 during reset and 1 after; no done pulse; next load of 8'h81 transmits cleanly.
5. MSB_FIRST=0, load 8'h01 -> bits 1,0,0,0,0,0,0,0.
6. Loopback into the 8-bit receiver on a shared shift_enable, word 8'h5A -> the receiver's output_data equals 8'h5A on the cycle done is asserted.
